rc4_prga_decrypt: RTL and testbench
===================================

# rc4_prga_decrypt

Consumer of the shuffled RC4 state array. After the key-schedule shuffle has permuted S-memory, this block runs the RC4 pseudo-random generation loop. For each ciphertext byte it swaps S[i] and S[j] in place, XORs the keystream byte with the encrypted-message ROM, and writes the plaintext to the decrypted-message RAM. It also checks every plaintext byte so the key-search controller can reject wrong keys early.

## Interface
- MSG_LEN, 32: message length in bytes; ROM/RAM depth.
- ABORT_ON_BAD, 1: 1 = stop at the first invalid plaintext byte; 0 = finish the message and only flag it.

- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; returns the block to IDLE.
- start  in  1  level; sampled only in IDLE or DONE.
- done  out  1  high while in DONE.
- bad_key  out  1  sticky; set on any invalid plaintext byte; cleared on start.
- s_addr  out  8  S-memory address.
- s_wrdata  out  8  S-memory write data.
- s_wren  out  1  S-memory write enable.
- s_rddata  in  8  S-memory read data.
- rom_addr  out  $clog2(MSG_LEN)  ciphertext ROM address.
- rom_rddata  in  8  ciphertext byte.
- ram_addr  out  $clog2(MSG_LEN)  plaintext RAM address.
- ram_wrdata  out  8  plaintext byte.
- ram_wren  out  1  plaintext RAM write enable.

## Operation
- All outputs are registered. Reset value of every output is 0. Internal i, j, k, si, sj and f also reset to 0.
- Memory reads have a 1-cycle latency: the address is registered on edge E and the data is sampled on edge E+2.
- Each state's actions are registered on the edge that leaves the state. Per byte k:
  - ADDR_I: i←i+1; s_addr←i+1.
  - WAIT_I: no action.
  - CAP_I: si←s_rddata; j←j+s_rddata; s_addr←j+s_rddata.
  - WAIT_J: no action.
  - CAP_J: sj←s_rddata; s_addr←i; s_wrdata←s_rddata; s_wren←1.
  - WR_J: s_addr←j; s_wrdata←si; s_wren←1.
  - ADDR_F: s_wren←0; s_addr←si+sj; rom_addr←k.
  - WAIT_F: no action.
  - CAP_F: ram_addr←k; ram_wrdata←s_rddata^rom_rddata; ram_wren←1; bad_key←1 if the byte is invalid.
  - NEXT: ram_wren←0. Go to DONE if k==MSG_LEN-1, or if ABORT_ON_BAD and bad_key. Otherwise k←k+1 and go to ADDR_I.
- IDLE→ADDR_I on start, clearing i, j, k and bad_key.
- DONE→ADDR_I on start (restart with the same clears). DONE holds otherwise.
- Arithmetic is 8-bit with natural mod-256 wrap for i, j and si+sj. k does not wrap; it terminates at MSG_LEN-1.
- Valid plaintext is 0x61–0x7A ('a'–'z') or 0x20 (space).
- i==j: both writes store the same value, leaving S unchanged. This is correct RC4 and needs no special case.
- start while busy is ignored.
- reset in any state returns to IDLE within one edge and drops all enables. A partially swapped S is left as-is; the owner re-runs init and shuffle.

## Timing
- 10 cycles per byte.
- done rises 10·MSG_LEN edges after the edge that samples start (320 for the default).
- On abort at byte k, done rises 10·(k+1) edges after start.
- s_wren is high for exactly 2 consecutive cycles per byte. ram_wren is high for exactly 1 cycle per byte.
- s_wren and ram_wren are never high in the same cycle.
- S-memory is owned exclusively by this block between start and done. The top-level mux switches on done.

## Structure
- rc4_pkg holds:
  - the state enum (IDLE, ADDR_I, WAIT_I, CAP_I, WAIT_J, CAP_J, WR_J, ADDR_F, WAIT_F, CAP_F, NEXT, DONE);
  - the constants CHAR_LO=8'h61, CHAR_HI=8'h7A, CHAR_SP=8'h20;
  - the default MSG_LEN.
- One sub-module, rc4_char_check: combinational, 8-bit in, valid out. It is shared with the future key-search controller.
- Main FSM and datapath stay in rc4_prga_decrypt.

## Test plan
- Identity S (S[n]=n), rom[0]=8'h63 → ram[0]=8'h61 (f=S[2]=2). Afterwards S[1]=1, unchanged.
- Identity S, rom[1]=8'h64 → ram[1]=8'h61 (i=2, j=3, f=5). After byte 1, S[2]=3 and S[3]=2.
- Identity S, rom[0]=8'h00, ABORT_ON_BAD=1 → ram[0]=8'h02 written, bad_key=1, done rises 10 edges after start, no write to ram[1].
- Same stimulus with ABORT_ON_BAD=0 → all 32 bytes written, bad_key=1, done at edge 320.
- Valid full message: a known key's S image and ciphertext → the plaintext matches a software RC4 model byte-for-byte, and the final S matches the model.
- reset asserted at byte 5 in WR_J → next edge: IDLE, all outputs 0. A subsequent start re-runs from k=0 and gives the correct result after S is reloaded.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 PRGA decrypt datapath.
package rc4_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned MSG_LEN_DEF = 32;

  // Plaintext alphabet: lowercase letters and space.
  localparam logic [BYTE_W-1:0] CHAR_LO = 8'h61;
  localparam logic [BYTE_W-1:0] CHAR_HI = 8'h7A;
  localparam logic [BYTE_W-1:0] CHAR_SP = 8'h20;

  typedef enum logic [3:0] {
    IDLE,
    ADDR_I,
    WAIT_I,
    CAP_I,
    WAIT_J,
    CAP_J,
    WR_J,
    ADDR_F,
    WAIT_F,
    CAP_F,
    NEXT,
    DONE
  } state_t;

endpackage

// File: rtl/rc4_char_check.sv
// Flags whether a plaintext byte belongs to the accepted alphabet.
module rc4_char_check
  import rc4_pkg::*;
(
  input  logic [7:0] ch,
  output logic       valid_c
);

  // Accept 'a'..'z' or space.
  always_comb begin
    valid_c = ((ch >= CHAR_LO) && (ch <= CHAR_HI)) || (ch == CHAR_SP);
  end

endmodule

// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generation over a pre-shuffled S-memory, decrypting a ROM
// message into a RAM and flagging out-of-alphabet plaintext.
module rc4_prga_decrypt
  import rc4_pkg::*;
#(
  parameter int unsigned MSG_LEN      = MSG_LEN_DEF,
  parameter bit          ABORT_ON_BAD = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       done,
  output logic                       bad_key,
  output logic [7:0]                 s_addr,
  output logic [7:0]                 s_wrdata,
  output logic                       s_wren,
  input  logic [7:0]                 s_rddata,
  output logic [$clog2(MSG_LEN)-1:0] rom_addr,
  input  logic [7:0]                 rom_rddata,
  output logic [$clog2(MSG_LEN)-1:0] ram_addr,
  output logic [7:0]                 ram_wrdata,
  output logic                       ram_wren
);

  localparam int unsigned AW = $clog2(MSG_LEN);
  localparam logic [AW-1:0] K_LAST = AW'(MSG_LEN - 1);

  state_t      state, state_n;
  logic [7:0]  i, i_n, j, j_n, si, si_n, sj, sj_n;
  logic [AW-1:0] k, k_n;
  logic        done_n, bad_key_n, s_wren_n, ram_wren_n;
  logic [7:0]  s_addr_n, s_wrdata_n, ram_wrdata_n;
  logic [AW-1:0] rom_addr_n, ram_addr_n;
  logic [7:0]  pt_c;
  logic        pt_valid_c;

  assign pt_c = s_rddata ^ rom_rddata;

  rc4_char_check u_char_check (
    .ch      (pt_c),
    .valid_c (pt_valid_c)
  );

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      i          <= '0;
      j          <= '0;
      k          <= '0;
      si         <= '0;
      sj         <= '0;
      done       <= 1'b0;
      bad_key    <= 1'b0;
      s_addr     <= '0;
      s_wrdata   <= '0;
      s_wren     <= 1'b0;
      rom_addr   <= '0;
      ram_addr   <= '0;
      ram_wrdata <= '0;
      ram_wren   <= 1'b0;
    end else begin
      state      <= state_n;
      i          <= i_n;
      j          <= j_n;
      k          <= k_n;
      si         <= si_n;
      sj         <= sj_n;
      done       <= done_n;
      bad_key    <= bad_key_n;
      s_addr     <= s_addr_n;
      s_wrdata   <= s_wrdata_n;
      s_wren     <= s_wren_n;
      rom_addr   <= rom_addr_n;
      ram_addr   <= ram_addr_n;
      ram_wrdata <= ram_wrdata_n;
      ram_wren   <= ram_wren_n;
    end
  end

  // Next-state and next-register values; each state's work lands on the edge leaving it.
  always_comb begin
    state_n      = state;
    i_n          = i;
    j_n          = j;
    k_n          = k;
    si_n         = si;
    sj_n         = sj;
    bad_key_n    = bad_key;
    s_addr_n     = s_addr;
    s_wrdata_n   = s_wrdata;
    s_wren_n     = s_wren;
    rom_addr_n   = rom_addr;
    ram_addr_n   = ram_addr;
    ram_wrdata_n = ram_wrdata;
    ram_wren_n   = ram_wren;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n   = ADDR_I;
          i_n       = '0;
          j_n       = '0;
          k_n       = '0;
          bad_key_n = 1'b0;
        end
      end
      ADDR_I: begin
        i_n      = i + 8'd1;
        s_addr_n = i + 8'd1;
        state_n  = WAIT_I;
      end
      WAIT_I: state_n = CAP_I;
      CAP_I: begin
        si_n     = s_rddata;
        j_n      = j + s_rddata;
        s_addr_n = j + s_rddata;
        state_n  = WAIT_J;
      end
      WAIT_J: state_n = CAP_J;
      CAP_J: begin
        sj_n       = s_rddata;
        s_addr_n   = i;
        s_wrdata_n = s_rddata;
        s_wren_n   = 1'b1;
        state_n    = WR_J;
      end
      WR_J: begin
        s_addr_n   = j;
        s_wrdata_n = si;
        s_wren_n   = 1'b1;
        state_n    = ADDR_F;
      end
      ADDR_F: begin
        s_wren_n   = 1'b0;
        s_addr_n   = si + sj;
        rom_addr_n = k;
        state_n    = WAIT_F;
      end
      WAIT_F: state_n = CAP_F;
      CAP_F: begin
        ram_addr_n   = k;
        ram_wrdata_n = pt_c;
        ram_wren_n   = 1'b1;
        if (!pt_valid_c) bad_key_n = 1'b1;
        state_n      = NEXT;
      end
      NEXT: begin
        ram_wren_n = 1'b0;
        if ((k == K_LAST) || (ABORT_ON_BAD && bad_key)) begin
          state_n = DONE;
        end else begin
          k_n     = k + AW'(1);
          state_n = ADDR_I;
        end
      end
      default: state_n = IDLE;
    endcase

    done_n = (state_n == DONE);
  end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Randomized bench: two instances (abort on / abort off) share stimulus and
// are compared against an array-based RC4 reference.
module tb_rc4_prga_decrypt;

  localparam int MSG_LEN = 32;
  localparam int AW      = 5;
  localparam int MAX_CYC = 400;

  logic clk, reset, start;
  logic          done       [2];
  logic          bad_key    [2];
  logic [7:0]    s_addr     [2];
  logic [7:0]    s_wrdata   [2];
  logic          s_wren     [2];
  logic [7:0]    s_rddata   [2];
  logic [AW-1:0] rom_addr   [2];
  logic [7:0]    rom_rddata [2];
  logic [AW-1:0] ram_addr   [2];
  logic [7:0]    ram_wrdata [2];
  logic          ram_wren   [2];

  logic [7:0] s_mem  [2][256];
  logic [7:0] ram    [2][MSG_LEN];
  logic [7:0] ct     [MSG_LEN];
  logic [7:0] s_init [256];

  logic [7:0] exp_pt  [2][MSG_LEN];
  logic [7:0] exp_s   [2][256];
  int         exp_n   [2];
  bit         exp_bad [2];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar u = 0; u < 2; u++) begin : g_dut
    rc4_prga_decrypt #(.MSG_LEN(MSG_LEN), .ABORT_ON_BAD(u == 0)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .done       (done[u]),
      .bad_key    (bad_key[u]),
      .s_addr     (s_addr[u]),
      .s_wrdata   (s_wrdata[u]),
      .s_wren     (s_wren[u]),
      .s_rddata   (s_rddata[u]),
      .rom_addr   (rom_addr[u]),
      .rom_rddata (rom_rddata[u]),
      .ram_addr   (ram_addr[u]),
      .ram_wrdata (ram_wrdata[u]),
      .ram_wren   (ram_wren[u])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memories: read returns the pre-write contents.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      s_rddata[u]   <= s_mem[u][s_addr[u]];
      rom_rddata[u] <= ct[rom_addr[u]];
      if (s_wren[u])   s_mem[u][s_addr[u]] = s_wrdata[u];
      if (ram_wren[u]) ram[u][ram_addr[u]] = ram_wrdata[u];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_valid(input logic [7:0] p);
    return ((p >= 8'h61) && (p <= 8'h7A)) || (p == 8'h20);
  endfunction

  // Reference RC4 PRGA on plain arrays.
  function automatic void model(input int u, input bit abort);
    int ii, jj, t;
    logic [7:0] tmp, p;
    for (int n = 0; n < 256; n++) exp_s[u][n] = s_init[n];
    ii = 0; jj = 0; exp_bad[u] = 1'b0; exp_n[u] = 0;
    for (int kk = 0; kk < MSG_LEN; kk++) begin
      ii = (ii + 1) % 256;
      jj = (jj + int'(exp_s[u][ii])) % 256;
      tmp = exp_s[u][ii]; exp_s[u][ii] = exp_s[u][jj]; exp_s[u][jj] = tmp;
      t = (int'(exp_s[u][ii]) + int'(exp_s[u][jj])) % 256;
      p = exp_s[u][t] ^ ct[kk];
      exp_pt[u][kk] = p;
      exp_n[u] = kk + 1;
      if (!is_valid(p)) exp_bad[u] = 1'b1;
      if (abort && exp_bad[u]) break;
    end
  endfunction

  function automatic logic [7:0] rand_char();
    int r;
    r = int'($urandom_range(0, 26));
    return (r == 26) ? 8'h20 : 8'(8'h61 + r);
  endfunction

  // Ciphertext whose plaintext is entirely valid under the current s_init.
  function automatic void make_valid_ct();
    for (int kk = 0; kk < MSG_LEN; kk++) ct[kk] = 8'h00;
    model(0, 1'b0);
    for (int kk = 0; kk < MSG_LEN; kk++) ct[kk] = exp_pt[0][kk] ^ rand_char();
  endfunction

  // Key schedule producing the shuffled S image for a random key.
  function automatic void ksa_random();
    logic [7:0] key [16];
    logic [7:0] tmp;
    int len, jj;
    len = int'($urandom_range(3, 16));
    for (int n = 0; n < 16; n++) key[n] = 8'($urandom);
    for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
    jj = 0;
    for (int n = 0; n < 256; n++) begin
      jj = (jj + int'(s_init[n]) + int'(key[n % len])) % 256;
      tmp = s_init[n]; s_init[n] = s_init[jj]; s_init[jj] = tmp;
    end
  endfunction

  function automatic void load_mems();
    for (int u = 0; u < 2; u++) begin
      for (int n = 0; n < 256; n++) s_mem[u][n] = s_init[n];
      for (int kk = 0; kk < MSG_LEN; kk++) ram[u][kk] = 8'hEE;
    end
  endfunction

  task automatic check_idle(input string tag);
    for (int u = 0; u < 2; u++) begin
      check_val($sformatf("%s_u%0d_done", tag, u), 32'(done[u]), 32'd0);
      check_val($sformatf("%s_u%0d_bad", tag, u), 32'(bad_key[u]), 32'd0);
      check_val($sformatf("%s_u%0d_swren", tag, u), 32'(s_wren[u]), 32'd0);
      check_val($sformatf("%s_u%0d_ramwren", tag, u), 32'(ram_wren[u]), 32'd0);
      check_val($sformatf("%s_u%0d_saddr", tag, u), 32'(s_addr[u]), 32'd0);
      check_val($sformatf("%s_u%0d_swdata", tag, u), 32'(s_wrdata[u]), 32'd0);
      check_val($sformatf("%s_u%0d_romaddr", tag, u), 32'(rom_addr[u]), 32'd0);
      check_val($sformatf("%s_u%0d_ramaddr", tag, u), 32'(ram_addr[u]), 32'd0);
      check_val($sformatf("%s_u%0d_ramwdata", tag, u), 32'(ram_wrdata[u]), 32'd0);
    end
  endtask

  // Start both instances, watch them to completion, then compare with the model.
  task automatic run_both(input string tag, input bit mid);
    int done_at [2];
    int swren_cnt [2];
    int ramw_cnt [2];
    int overlap;
    logic [7:0] want;
    overlap = 0;
    for (int u = 0; u < 2; u++) begin done_at[u] = -1; swren_cnt[u] = 0; ramw_cnt[u] = 0; end
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= MAX_CYC; cyc++) begin
      @(posedge clk);
      #1;
      for (int u = 0; u < 2; u++) begin
        if (s_wren[u]) swren_cnt[u]++;
        if (ram_wren[u]) ramw_cnt[u]++;
        if (s_wren[u] && ram_wren[u]) overlap++;
        if (done[u] && done_at[u] < 0) done_at[u] = cyc;
      end
      if (mid && cyc == 10) check_val({tag, "_s1_after_b0"}, 32'(s_mem[0][1]), 32'd1);
      if (mid && cyc == 20) begin
        check_val({tag, "_s2_after_b1"}, 32'(s_mem[0][2]), 32'd3);
        check_val({tag, "_s3_after_b1"}, 32'(s_mem[0][3]), 32'd2);
      end
      if (done_at[0] >= 0 && done_at[1] >= 0) break;
    end
    check_val({tag, "_wren_overlap"}, 32'(overlap), 32'd0);
    for (int u = 0; u < 2; u++) begin
      check_val($sformatf("%s_u%0d_done_at", tag, u), 32'(done_at[u]), 32'(10 * exp_n[u]));
      check_val($sformatf("%s_u%0d_bad_key", tag, u), 32'(bad_key[u]), 32'(exp_bad[u]));
      check_val($sformatf("%s_u%0d_ram_writes", tag, u), 32'(ramw_cnt[u]), 32'(exp_n[u]));
      check_val($sformatf("%s_u%0d_s_wren_cycles", tag, u), 32'(swren_cnt[u]), 32'(2 * exp_n[u]));
      for (int kk = 0; kk < MSG_LEN; kk++) begin
        want = (kk < exp_n[u]) ? exp_pt[u][kk] : 8'hEE;
        check_val($sformatf("%s_u%0d_ram%0d", tag, u, kk), 32'(ram[u][kk]), 32'(want));
      end
      for (int n = 0; n < 256; n++)
        check_val($sformatf("%s_u%0d_s%0d", tag, u, n), 32'(s_mem[u][n]), 32'(exp_s[u][n]));
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
    for (int kk = 0; kk < MSG_LEN; kk++) ct[kk] = 8'h00;
    load_mems();
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    reset = 1'b0;

    // Identity S, hand-derived first two bytes.
    for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
    make_valid_ct();
    ct[0] = 8'h63;
    ct[1] = 8'h64;
    model(0, 1'b1); model(1, 1'b0);
    load_mems();
    run_both("ident", 1'b1);
    check_val("ident_pt0", 32'(ram[0][0]), 32'h61);
    check_val("ident_pt1", 32'(ram[0][1]), 32'h61);

    // Identity S, invalid first byte: abort vs flag-only.
    ct[0] = 8'h00;
    model(0, 1'b1); model(1, 1'b0);
    load_mems();
    run_both("badfirst", 1'b0);
    check_val("badfirst_pt0", 32'(ram[0][0]), 32'h02);
    check_val("badfirst_ram1_untouched", 32'(ram[0][1]), 32'hEE);
    check_val("badfirst_u1_bad", 32'(bad_key[1]), 32'd1);

    // Random keys with valid plaintext.
    for (int r = 0; r < 3; r++) begin
      ksa_random();
      make_valid_ct();
      model(0, 1'b1); model(1, 1'b0);
      load_mems();
      run_both($sformatf("key%0d", r), 1'b0);
    end

    // Random key, random ciphertext.
    ksa_random();
    for (int kk = 0; kk < MSG_LEN; kk++) ct[kk] = 8'($urandom);
    model(0, 1'b1); model(1, 1'b0);
    load_mems();
    run_both("randct", 1'b0);

    // Reset during byte 5 WR_J, then reload and rerun.
    ksa_random();
    make_valid_ct();
    model(0, 1'b1); model(1, 1'b0);
    load_mems();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (55) @(posedge clk);
    #1;
    check_val("rst_in_wrj_swren", 32'(s_wren[0]), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_idle("midreset");
    reset = 1'b0;
    load_mems();
    run_both("after_rst", 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
